bcd_down_timer: RTL and testbench
=================================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter: DIGITS, 4, number of cascaded BCD digits; Count width = 4*DIGITS.
REQ-002 Port: clk  input  1  the only clock; all state updates on the negative edge.
REQ-003 Port: Clear  input  1  reset, synchronous and active-low; sampled on the clk negedge.
REQ-004 Port: Load  input  1  when high, preset Count from LoadValue.
REQ-005 Port: LoadValue  input  4*DIGITS  BCD preset value; digit 0 is in bits [3:0].
REQ-006 Port: Start  input  1  start a countdown, or resume a paused one.
REQ-007 Port: Stop  input  1  pause a running countdown.
REQ-008 Port: Enable  input  1  count-tick qualifier; the counter decrements only on cycles where Enable=1.
REQ-009 Port: Count  output reg  4*DIGITS  current BCD value.
REQ-010 Port: Busy  output reg  1  high in the RUN state.
REQ-011 Port: Done  output reg  1  high in the DONE state.
REQ-012 Port: TC  output reg  1  terminal-count pulse, high for exactly one cycle when the FSM enters DONE.

Function
REQ-013 The FSM shall have four states: IDLE, RUN, PAUSE and DONE.
REQ-014 Priority on every negedge shall be Clear, then Load, then Stop, then Start, then the count tick.
REQ-015 Load in any state shall write LoadValue into Count, force the state to IDLE and deassert TC.
REQ-016 Any LoadValue digit greater than 9 shall be stored as 9; the other digits are stored unchanged.
REQ-017 Start in IDLE shall go to RUN when Count≠0, and to DONE (with TC pulse) when Count=0.
REQ-018 Start in PAUSE shall return to RUN with Count unchanged.
REQ-019 Start in RUN or DONE shall have no effect.
REQ-020 Stop in RUN shall go to PAUSE with Count unchanged; Stop in any other state has no effect.
REQ-021 In RUN with Enable=1, Count shall decrement by one in BCD.
  - A digit at 0 wraps to 9 and borrows from the next-higher digit.
  - The other digits do not change.
REQ-022 In RUN with Enable=0, Count shall hold.
REQ-023 A RUN decrement that produces Count=0 shall move the FSM to DONE on the same edge.
  - TC=1 for that following cycle only.
REQ-024 Count shall never underflow.
  - DONE holds Count=0 regardless of Enable.
  - Only Load or Clear leaves DONE.
REQ-025 The decrement latency shall be 1 cycle: the new Count is visible after the negedge on which Enable=1 was sampled.
REQ-026 In IDLE and PAUSE, Count shall hold regardless of Enable.
REQ-027 Busy=1 exactly in RUN, and Done=1 exactly in DONE; both are registered outputs.
REQ-028 Count shall remain valid BCD at all times; no digit ever exceeds 9.

Reset
REQ-029 Clear=0 on a negedge shall set Count=0, state=IDLE, Busy=0, Done=0 and TC=0, overriding all other inputs.
REQ-030 Clear applied mid-RUN shall abort the countdown with no TC pulse.
REQ-031 After Clear returns to 1, the block shall be idle until Load or Start is applied.

Verification
REQ-032 Basic countdown:
  - Stimulus: Load 0x0003, then Start, then Enable=1 continuously.
  - Response: Count goes 0003, 0002, 0001, 0000.
  - Done=1 and TC pulses once on the cycle Count=0000 appears; Count then stays 0000.
REQ-033 Borrow chain:
  - Stimulus: Load 0x1000, Start, one Enable tick.
  - Response: Count=0999, Busy=1.
REQ-034 Pause and resume:
  - Stimulus: Load 0x0050, Start, 5 ticks, Stop, 3 cycles with Enable=1, Start, 1 tick.
  - Response: Count=0045 while paused, then 0044.
REQ-035 Priorities:
  - Stimulus: Start and Stop together in RUN.
  - Response: PAUSE.
  - Stimulus: Load and Start together.
  - Response: IDLE with Count=LoadValue.
  - Stimulus: Load 0x0A0F.
  - Response: Count=0909.
REQ-036 Start at zero:
  - Stimulus: Clear, then Start.
  - Response: DONE immediately, TC=1 for one cycle, Count=0000.
REQ-037 Reset mid-operation:
  - Stimulus: Clear=0 during RUN at Count=0123.
  - Response: Count=0000, Busy=0, Done=0, TC=0 after the next negedge.
  - No further decrements until Load and Start.

Source files
------------

// File: rtl/bcd_down_timer.sv
// bcd_down_timer
// ---------------------------------------------------------------------------
// Purpose:
//   Cascaded BCD down-counter with a small control FSM (IDLE/RUN/PAUSE/DONE).
//   All state updates happen on the falling edge of clk. The counter is
//   preset with Load and started with Start. In RUN it decrements once per
//   cycle on which Enable is high. It stops at zero, entering DONE with a
//   one-cycle terminal-count pulse.
//
// Parameters:
//   DIGITS     number of cascaded BCD digits (Count width = 4*DIGITS)
//
// Ports:
//   clk        in   clock; every register updates on its negative edge
//   Clear      in   synchronous active-low clear, highest priority
//   Load       in   preset Count from LoadValue and return to IDLE
//   LoadValue  in   BCD preset; digit 0 in bits [3:0]; digits >9 saturate to 9
//   Start      in   start from IDLE or resume from PAUSE
//   Stop       in   pause a running countdown
//   Enable     in   count-tick qualifier while in RUN
//   Count      out  current BCD value (registered)
//   Busy       out  high in RUN (registered)
//   Done       out  high in DONE (registered)
//   TC         out  one-cycle pulse on entry to DONE (registered)
// ---------------------------------------------------------------------------
module bcd_down_timer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                Clear,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadValue,
  input  logic                Start,
  input  logic                Stop,
  input  logic                Enable,
  output logic [4*DIGITS-1:0] Count,
  output logic                Busy,
  output logic                Done,
  output logic                TC
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;
  logic           tc_q,    tc_d;

  // Clamp every digit of a preset to the legal BCD range so Count can never
  // hold a non-decimal digit, whatever the source drives.
  function automatic logic [W-1:0] bcd_saturate(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // BCD decrement by one: a zero digit wraps to 9 and passes the borrow
  // upward; the first non-zero digit absorbs the borrow and the digits above
  // it are untouched. Callers never present zero, so no underflow case exists.
  function automatic logic [W-1:0] bcd_decrement(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] count_dec;
  assign count_dec = bcd_decrement(count_q);

  // Next-state logic. Priority is Load, Stop, Start, then the count tick.
  // A command only claims the edge when it acts in the current state, so
  // e.g. a Start held while in RUN does not swallow a tick.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;

    if (Load) begin
      count_d = bcd_saturate(LoadValue);
      state_d = S_IDLE;
    end else if (Stop && (state_q == S_RUN)) begin
      state_d = S_PAUSE;
    end else if (Start && (state_q == S_IDLE)) begin
      if (count_q == '0) begin
        state_d = S_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else if (Start && (state_q == S_PAUSE)) begin
      state_d = S_RUN;
    end else if (Enable && (state_q == S_RUN)) begin
      count_d = count_dec;
      // Reaching zero ends the run on the same edge as the final decrement.
      if (count_dec == '0) begin
        state_d = S_DONE;
        tc_d    = 1'b1;
      end
    end

    // Status flags are decoded from the next state so the outputs come
    // straight from flops and line up with the state register.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // All registers, including the FSM state, update on the falling edge.
  // Clear is synchronous and overrides every other input, so a countdown
  // aborted by Clear never produces a TC pulse.
  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, regardless of statement order.
    if (!Clear) begin
      state_q <= S_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
    end
  end

  assign Count = count_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign TC    = tc_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer
// ---------------------------------------------------------------------------
// Directed test of bcd_down_timer. Inputs change 1 ns after each falling
// edge. Outputs are checked at that same point, after the DUT has updated.
// Every expected value below is hand-computed.
// ---------------------------------------------------------------------------
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         Clear;
  logic         Load;
  logic [W-1:0] LoadValue;
  logic         Start;
  logic         Stop;
  logic         Enable;
  logic [W-1:0] Count;
  logic         Busy;
  logic         Done;
  logic         TC;

  int errors = 0;
  int checks = 0;

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .Clear     (Clear),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Start     (Start),
    .Stop      (Stop),
    .Enable    (Enable),
    .Count     (Count),
    .Busy      (Busy),
    .Done      (Done),
    .TC        (TC)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one falling edge; the DUT has updated when this returns.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [W-1:0] c,
                            input logic b, input logic d, input logic t);
    check({tag, ".count"}, 32'(Count), 32'(c));
    check({tag, ".busy"},  32'(Busy),  32'(b));
    check({tag, ".done"},  32'(Done),  32'(d));
    check({tag, ".tc"},    32'(TC),    32'(t));
  endtask

  task automatic idle_inputs();
    Load   = 1'b0;
    Start  = 1'b0;
    Stop   = 1'b0;
    Enable = 1'b0;
  endtask

  // Load a value, then Start; leaves the DUT in RUN with Count untouched.
  task automatic load_and_start(input logic [W-1:0] v);
    idle_inputs();
    Load = 1'b1; LoadValue = v;
    step();
    Load = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  initial begin
    Clear = 1'b0; LoadValue = '0;
    idle_inputs();
    Start = 1'b1; Load = 1'b1; LoadValue = 16'h1234; Enable = 1'b1;

    // Clear overrides everything.
    step();
    expect_all("reset", 16'h0000, 0, 0, 0);
    Clear = 1'b1;
    idle_inputs();

    // Idle after reset: nothing moves without Load/Start.
    Enable = 1'b1;
    step();
    expect_all("post_reset_idle", 16'h0000, 0, 0, 0);

    // Basic countdown 3 -> 0.
    idle_inputs();
    Load = 1'b1; LoadValue = 16'h0003;
    step();
    expect_all("basic.load", 16'h0003, 0, 0, 0);
    Load = 1'b0; Start = 1'b1;
    step();
    expect_all("basic.start", 16'h0003, 1, 0, 0);
    Start = 1'b0; Enable = 1'b1;
    step();
    expect_all("basic.2", 16'h0002, 1, 0, 0);
    step();
    expect_all("basic.1", 16'h0001, 1, 0, 0);
    step();
    expect_all("basic.0", 16'h0000, 0, 1, 1);
    step();
    expect_all("basic.hold", 16'h0000, 0, 1, 0);
    Start = 1'b1;
    step();
    expect_all("basic.start_in_done", 16'h0000, 0, 1, 0);

    // Borrow chain across three digits, then hold with Enable low.
    load_and_start(16'h1000);
    Enable = 1'b1;
    step();
    expect_all("borrow.0999", 16'h0999, 1, 0, 0);
    Enable = 1'b0;
    step();
    expect_all("borrow.hold", 16'h0999, 1, 0, 0);

    // Pause and resume.
    load_and_start(16'h0050);
    Enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    expect_all("pause.run5", 16'h0045, 1, 0, 0);
    Stop = 1'b1;
    step();
    expect_all("pause.stop", 16'h0045, 0, 0, 0);
    Stop = 1'b0;
    for (int i = 0; i < 3; i++) step();
    expect_all("pause.hold", 16'h0045, 0, 0, 0);
    Start = 1'b1;
    step();
    expect_all("pause.resume", 16'h0045, 1, 0, 0);
    Start = 1'b0;
    step();
    expect_all("pause.tick", 16'h0044, 1, 0, 0);

    // Start with Stop in RUN -> PAUSE.
    Start = 1'b1; Stop = 1'b1;
    step();
    expect_all("prio.start_stop", 16'h0044, 0, 0, 0);

    // Load with Start -> IDLE, digits above 9 saturate.
    Stop = 1'b0; Load = 1'b1; LoadValue = 16'h0A0F;
    step();
    expect_all("prio.load_start", 16'h0909, 0, 0, 0);
    idle_inputs();
    Enable = 1'b1;
    step();
    expect_all("prio.idle_hold", 16'h0909, 0, 0, 0);

    // Start at zero goes straight to DONE with a single TC pulse.
    idle_inputs();
    Clear = 1'b0;
    step();
    Clear = 1'b1; Start = 1'b1;
    step();
    expect_all("zero.start", 16'h0000, 0, 1, 1);
    Start = 1'b0;
    step();
    expect_all("zero.after", 16'h0000, 0, 1, 0);

    // Load clears DONE.
    Load = 1'b1; LoadValue = 16'h0007;
    step();
    expect_all("done.load", 16'h0007, 0, 0, 0);

    // Clear mid-run aborts without TC.
    load_and_start(16'h0125);
    Enable = 1'b1;
    step();
    step();
    expect_all("abort.pre", 16'h0123, 1, 0, 0);
    Clear = 1'b0;
    step();
    expect_all("abort.clear", 16'h0000, 0, 0, 0);
    Clear = 1'b1;
    for (int i = 0; i < 3; i++) step();
    expect_all("abort.idle", 16'h0000, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
